// File: rtl/hazard_pkg.sv
// Shared constants and types for the Decode/Execute/WriteBack hazard controller.
package hazard_pkg;

  localparam int NREGS      = 16;
  localparam int REG_W      = $clog2(NREGS);
  localparam int MC_LATENCY = 4;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      use_a;
    reg_addr_t src_a;
    logic      use_b;
    reg_addr_t src_b;
    logic      writes;
    reg_addr_t dst;
    logic      multicycle;
  } id_req_t;

endpackage

// File: rtl/pipeline_hazard_controller_scoreboard.sv
// Per-register pending-write scoreboard with same-cycle commit-aware lookups.
module hazard_scoreboard #(
  parameter int NREGS     = hazard_pkg::NREGS,
  parameter int REG_W     = $clog2(NREGS),
  parameter bit REG0_ZERO = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic [REG_W-1:0] look_a,
  input  logic [REG_W-1:0] look_b,
  input  logic [REG_W-1:0] look_d,
  output logic [NREGS-1:0] pending,
  output logic             eff_a,
  output logic             eff_b,
  output logic             eff_d,
  output logic             pend_a,
  output logic             pend_b,
  output logic             pend_wb
);

  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;

  // A register still counts as pending unless WriteBack retires it this very cycle.
  function automatic logic eff_pend(input logic [NREGS-1:0] pend, input logic [REG_W-1:0] r,
                                    input logic cen, input logic [REG_W-1:0] cidx);
    return pend[r] & ~(cen & (cidx == r)) & ~(REG0_ZERO & (r == {REG_W{1'b0}}));
  endfunction

  // Next-state: clear before set so a same-register set/clear leaves the bit set.
  always_comb begin
    clr_mask  = clr_en ? (ONE_HOT0 << clr_idx) : {NREGS{1'b0}};
    set_mask  = set_en ? (ONE_HOT0 << set_idx) : {NREGS{1'b0}};
    pending_d = flush ? {NREGS{1'b0}} : ((pending_q & ~clr_mask) | set_mask);
    eff_a     = eff_pend(pending_q, look_a, clr_en, clr_idx);
    eff_b     = eff_pend(pending_q, look_b, clr_en, clr_idx);
    eff_d     = eff_pend(pending_q, look_d, clr_en, clr_idx);
    pend_a    = pending_q[look_a];
    pend_b    = pending_q[look_b];
    pend_wb   = pending_q[clr_idx];
  end

  // Scoreboard state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= {NREGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Issue gating for Decode: RAW/WAW hazards, multi-cycle Execute occupancy and WB bypass.
module pipeline_hazard_controller #(
  parameter int NREGS      = hazard_pkg::NREGS,
  parameter int REG_W      = $clog2(NREGS),
  parameter int MC_LATENCY = hazard_pkg::MC_LATENCY,
  parameter bit REG0_ZERO  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_use_a,
  input  logic [REG_W-1:0] id_src_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_multicycle,
  input  logic             wb_commit,
  input  logic [REG_W-1:0] wb_dst,
  output logic             issue,
  output logic             stalled,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             mc_busy,
  output logic [NREGS-1:0] pending,
  output logic             sb_error
);
  import hazard_pkg::*;

  localparam int MC_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

  id_req_t         req;
  logic            eff_a, eff_b, eff_d;
  logic            pend_a, pend_b, pend_wb;
  logic            raw_a, raw_b, waw;
  logic            set_en;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic            sb_error_q, sb_error_d;

  hazard_scoreboard #(
    .NREGS(NREGS), .REG_W(REG_W), .REG0_ZERO(REG0_ZERO)
  ) u_sb (
    .clock(clock), .reset(reset), .flush(flush),
    .clr_en(wb_commit), .clr_idx(wb_dst),
    .set_en(set_en), .set_idx(req.dst),
    .look_a(req.src_a), .look_b(req.src_b), .look_d(req.dst),
    .pending(pending),
    .eff_a(eff_a), .eff_b(eff_b), .eff_d(eff_d),
    .pend_a(pend_a), .pend_b(pend_b), .pend_wb(pend_wb)
  );

  // Issue decision, bypass grants and next-state for the counter and error flag.
  always_comb begin
    req        = '{valid: id_valid, use_a: id_use_a, src_a: id_src_a, use_b: id_use_b,
                   src_b: id_src_b, writes: id_writes, dst: id_dst, multicycle: id_multicycle};
    mc_busy    = (mc_cnt_q != {MC_W{1'b0}});
    raw_a      = req.use_a & eff_a;
    raw_b      = req.use_b & eff_b;
    waw        = req.writes & eff_d;
    // Reset also masks the combinational outputs so everything reads 0 while held.
    issue      = req.valid & ~reset & ~flush & ~raw_a & ~raw_b & ~waw & ~mc_busy;
    stalled    = req.valid & ~reset & ~issue;
    fwd_a      = issue & req.use_a & pend_a & wb_commit & (wb_dst == req.src_a);
    fwd_b      = issue & req.use_b & pend_b & wb_commit & (wb_dst == req.src_b);
    set_en     = issue & req.writes & ~(REG0_ZERO & (req.dst == {REG_W{1'b0}}));
    mc_cnt_d   = flush ? {MC_W{1'b0}} :
                 (issue & req.multicycle) ? MC_W'(MC_LATENCY - 1) :
                 mc_busy ? (mc_cnt_q - {{(MC_W-1){1'b0}}, 1'b1}) : mc_cnt_q;
    sb_error_d = sb_error_q | (wb_commit & ~pend_wb & ~flush &
                               ~(REG0_ZERO & (wb_dst == {REG_W{1'b0}})));
  end

  // Multi-cycle occupancy counter and sticky scoreboard error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mc_cnt_q   <= {MC_W{1'b0}};
      sb_error_q <= 1'b0;
    end else begin
      mc_cnt_q   <= mc_cnt_d;
      sb_error_q <= sb_error_d;
    end
  end

  assign sb_error = sb_error_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        id_valid, id_use_a, id_use_b, id_writes, id_multicycle, wb_commit;
  logic [3:0]  id_src_a, id_src_b, id_dst, wb_dst;
  logic        issue, stalled, fwd_a, fwd_b, mc_busy, sb_error;
  logic [15:0] pending;
  int          n_checks = 0;
  int          n_pass   = 0;

  pipeline_hazard_controller dut (
    .clock(clock), .reset(reset), .flush(flush),
    .id_valid(id_valid), .id_use_a(id_use_a), .id_src_a(id_src_a),
    .id_use_b(id_use_b), .id_src_b(id_src_b), .id_writes(id_writes),
    .id_dst(id_dst), .id_multicycle(id_multicycle),
    .wb_commit(wb_commit), .wb_dst(wb_dst),
    .issue(issue), .stalled(stalled), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mc_busy(mc_busy), .pending(pending), .sb_error(sb_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_use_a = 1'b0; id_use_b = 1'b0; id_writes = 1'b0;
    id_multicycle = 1'b0; wb_commit = 1'b0;
    id_src_a = 4'd0; id_src_b = 4'd0; id_dst = 4'd0; wb_dst = 4'd0;
  endtask

  task automatic instr(input logic ua, input logic [3:0] sa, input logic ub, input logic [3:0] sb,
                       input logic wr, input logic [3:0] d, input logic mc);
    id_valid = 1'b1; id_use_a = ua; id_src_a = sa; id_use_b = ub; id_src_b = sb;
    id_writes = wr; id_dst = d; id_multicycle = mc;
  endtask

  task automatic commit(input logic [3:0] d);
    wb_commit = 1'b1; wb_dst = d;
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; idle();
    instr(1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
    #1;
    n_checks++; if (issue !== 1'b0) $display("FAIL reset_issue got %b want 0", issue); else n_pass++;
    n_checks++; if (stalled !== 1'b0) $display("FAIL reset_stalled got %b want 0", stalled); else n_pass++;
    n_checks++; if ({pending, mc_busy, sb_error} !== 18'd0)
      $display("FAIL reset_state got %h/%b/%b want 0", pending, mc_busy, sb_error); else n_pass++;
    tick(); tick();
    reset = 1'b0; idle();
    #1;
  endtask

  task automatic test_independent();
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0); #1;
    n_checks++; if (issue !== 1'b1) $display("FAIL indep_w1 issue got %b want 1", issue); else n_pass++;
    tick();
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0); #1;
    n_checks++; if (issue !== 1'b1) $display("FAIL indep_w2 issue got %b want 1", issue); else n_pass++;
    tick();
    instr(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); #1;
    n_checks++; if (issue !== 1'b1) $display("FAIL indep_r3 issue got %b want 1", issue); else n_pass++;
    n_checks++; if (pending !== 16'h0006) $display("FAIL indep_pending got %h want 0006", pending); else n_pass++;
    tick();
    do_flush();
  endtask

  task automatic test_raw();
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0); tick();
    instr(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); #1;
    n_checks++; if ({issue, stalled} !== 2'b01) $display("FAIL raw_stall got %b want 01", {issue, stalled}); else n_pass++;
    tick(); #1;
    n_checks++; if (stalled !== 1'b1) $display("FAIL raw_stall2 got %b want 1", stalled); else n_pass++;
    commit(4'd5); #1;
    n_checks++; if ({issue, fwd_a, fwd_b, stalled} !== 4'b1100)
      $display("FAIL raw_fwd_a got %b want 1100", {issue, fwd_a, fwd_b, stalled}); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (pending[5] !== 1'b0) $display("FAIL raw_clear got %b want 0", pending[5]); else n_pass++;
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd6, 1'b0); tick();
    instr(1'b1, 4'd2, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0); commit(4'd6); #1;
    n_checks++; if ({issue, fwd_a, fwd_b} !== 3'b101)
      $display("FAIL raw_fwd_b got %b want 101", {issue, fwd_a, fwd_b}); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if ({pending, sb_error} !== 17'd0)
      $display("FAIL raw_end got %h/%b want 0000/0", pending, sb_error); else n_pass++;
  endtask

  task automatic test_waw();
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0); tick();
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0); #1;
    n_checks++; if ({issue, stalled} !== 2'b01) $display("FAIL waw_stall got %b want 01", {issue, stalled}); else n_pass++;
    commit(4'd7); #1;
    n_checks++; if (issue !== 1'b1) $display("FAIL waw_commit_issue got %b want 1", issue); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (pending !== 16'h0080) $display("FAIL waw_set_wins got %h want 0080", pending); else n_pass++;
    do_flush();
  endtask

  task automatic test_multicycle();
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1); #1;
    n_checks++; if ({issue, mc_busy} !== 2'b10) $display("FAIL mc_load got %b want 10", {issue, mc_busy}); else n_pass++;
    tick();
    instr(1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_checks++; if ({mc_busy, issue, stalled} !== 3'b101)
        $display("FAIL mc_busy_c%0d got %b want 101", i, {mc_busy, issue, stalled}); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if ({mc_busy, issue, stalled} !== 3'b010)
      $display("FAIL mc_release got %b want 010", {mc_busy, issue, stalled}); else n_pass++;
    tick();
    do_flush();
  endtask

  task automatic test_reg0_error();
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0); #1;
    n_checks++; if (issue !== 1'b1) $display("FAIL r0_write_issue got %b want 1", issue); else n_pass++;
    tick();
    instr(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0); #1;
    n_checks++; if ({pending, issue} !== 17'h00001)
      $display("FAIL r0_never_pending got %h/%b want 0000/1", pending, issue); else n_pass++;
    idle(); commit(4'd0); tick(); idle(); #1;
    n_checks++; if (sb_error !== 1'b0) $display("FAIL r0_commit_err got %b want 0", sb_error); else n_pass++;
    commit(4'd9); #1;
    n_checks++; if (sb_error !== 1'b0) $display("FAIL err_registered got %b want 0", sb_error); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (sb_error !== 1'b1) $display("FAIL err_set got %b want 1", sb_error); else n_pass++;
    tick(); tick(); #1;
    n_checks++; if (sb_error !== 1'b1) $display("FAIL err_sticky got %b want 1", sb_error); else n_pass++;
  endtask

  task automatic test_flush_reset();
    for (int r = 4; r <= 6; r++) begin
      instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'(r), 1'b0); tick();
    end
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b1); tick();
    idle(); tick();
    instr(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); #1;
    n_checks++; if ({pending, mc_busy, stalled} !== 18'h003C3)
      $display("FAIL flush_setup got %h/%b/%b want 00f0/1/1", pending, mc_busy, stalled); else n_pass++;
    mc_cnt_dec_check: begin end
    tick(); #1;
    idle(); instr(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); flush = 1'b1; #1;
    n_checks++; if ({issue, stalled, mc_busy} !== 3'b011)
      $display("FAIL flush_gate got %b want 011", {issue, stalled, mc_busy}); else n_pass++;
    tick(); flush = 1'b0; idle(); #1;
    n_checks++; if ({pending, mc_busy, sb_error} !== 18'h00001)
      $display("FAIL flush_clear got %h/%b/%b want 0000/0/1", pending, mc_busy, sb_error); else n_pass++;
    instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1); tick();
    instr(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); commit(4'd3); #1;
    n_checks++; if ({pending, mc_busy, fwd_a} !== 18'h00022)
      $display("FAIL prereset got %h/%b/%b want 0008/1/0", pending, mc_busy, fwd_a); else n_pass++;
    #2 reset = 1'b1; #1;
    n_checks++; if ({issue, stalled, fwd_a, fwd_b, mc_busy, sb_error, pending} !== 22'd0)
      $display("FAIL async_reset got %b/%h want all 0", {issue, stalled, fwd_a, fwd_b, mc_busy, sb_error}, pending);
    else n_pass++;
    tick(); reset = 1'b0; idle(); tick();
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_waw();
    test_multicycle();
    test_reg0_error();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Issue scheduler for the Decode→Execute→WriteBack pipeline. It keeps a per-register pending-write scoreboard and gates instruction issue out of Decode on RAW/WAW hazards and on multi-cycle Execute occupancy. It grants a WriteBack-to-Decode bypass when a blocking write commits in the same cycle. It drives the pipeline-wide stall and is cleared by the internal soft reset (flush).

Parameters:
NREGS, 16, number of architectural registers (power of 2)
REG_W, $clog2(NREGS), register address width
MC_LATENCY, 4, Execute cycles occupied by a multi-cycle op (≥2)
REG0_ZERO, 1, register 0 hardwired zero: never pending, never hazards

Ports:
clock  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high global reset
flush  input  1  synchronous soft reset (internal_reset); clears state
id_valid  input  1  Decode holds a valid instruction
id_use_a  input  1  instruction reads source A
id_src_a  input  REG_W  source A register
id_use_b  input  1  instruction reads source B
id_src_b  input  REG_W  source B register
id_writes  input  1  instruction writes a destination
id_dst  input  REG_W  destination register
id_multicycle  input  1  instruction is a multi-cycle Execute op
wb_commit  input  1  WriteBack commits a register write this cycle
wb_dst  input  REG_W  WriteBack destination
issue  output  1  Decode instruction advances to Execute this cycle
stalled  output  1  id_valid & ~issue
fwd_a  output  1  source A taken from WriteBack bypass
fwd_b  output  1  source B taken from WriteBack bypass
mc_busy  output  1  multi-cycle op occupying Execute
pending  output  NREGS  scoreboard, bit i = write to reg i in flight
sb_error  output  1  sticky: commit to a non-pending register

Behaviour:
- Reset (async, any cycle): pending=0, mc counter=0, sb_error=0. Combinational outputs follow: issue=stalled=fwd_a=fwd_b=mc_busy=0.
- clr(r) = wb_commit & (wb_dst==r). eff_pend(r) = pending[r] & ~clr(r); always 0 for r=0 when REG0_ZERO.
- raw_a = id_use_a & eff_pend(id_src_a); same for raw_b. waw = id_writes & eff_pend(id_dst).
- fwd_a = issue & id_use_a & pending[id_src_a] & clr(id_src_a); same for fwd_b. Bypass costs zero stall cycles.
- issue = id_valid & ~flush & ~raw_a & ~raw_b & ~waw & ~mc_busy. All outputs except pending/mc_busy/sb_error are combinational; latency from input to issue is 0 cycles.
- Scoreboard update on each edge, in order: clear bit wb_dst if wb_commit, then set bit id_dst if issue & id_writes (& id_dst≠0 when REG0_ZERO). If both hit the same register, set wins.
- Multi-cycle counter: on issue & id_multicycle, load MC_LATENCY-1; else if nonzero, decrement. mc_busy = (count≠0). Blocks all issue, in order; the multi-cycle op itself issues in the load cycle.
- sb_error set when wb_commit & ~pending[wb_dst] (excluding reg 0 when REG0_ZERO) and not flushing; cleared only by reset.
- flush (sync, priority over all updates): pending←0, counter←0, issue forced 0; sb_error held.
- Reset deasserted mid-stream: state starts clean; in-flight commits arriving afterwards raise sb_error (expected; bench must flush or reset the whole pipeline together).

Decomposition:
- Package hazard_pkg: REG_W/NREGS constants, reg_addr_t typedef, MC_LATENCY default, a struct bundling id_* request fields.
- One sub-module: hazard_scoreboard (pending vector, set/clear/flush, eff_pend lookup ×3). Issue logic and mc counter stay in top.

Test Plan:
- Independent stream: write r1, write r2, read r3 back-to-back, no commits → issue=1 each cycle; pending=0x0006 after 2 cycles.
- RAW: issue write r5; next cycle read r5 with no commit → stalled=1. Commit r5 in a later cycle → same cycle issue=1, fwd_a=1, pending[5]=0.
- WAW plus same-cycle set/clear: pending[7]=1, write r7 with wb_commit r7 → issue=1, pending[7] remains 1.
- Multi-cycle: issue mc op with MC_LATENCY=4 → mc_busy for 3 cycles, next instruction issues on cycle 4, stalled=1 in between.
- Register 0 and error: write r0 → pending[0]=0; read r0 never stalls; commit r9 with pending[9]=0 → sb_error=1 and stays 1.
- Flush/reset: pending=0x00F0 with counter=2, assert flush → issue=0 that cycle, next cycle pending=0, mc_busy=0. Async reset mid-cycle → all outputs 0 immediately.
